// File: rtl/core_write_sequencer.sv
// rtl/core_write_sequencer.sv - core-storage read/regenerate/write cycle sequencer (optional CORE_PARITY_CHECK_EN)
module core_write_sequencer #(
    parameter int ADDR_W    = 15,
    parameter int READ_CYC  = 4,
    parameter int WRITE_CYC = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [5:0]        wdata_i,
    input  logic [5:0]        sense_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] drv_addr_o,
    output logic              drv_read_o,
    output logic              drv_write_o,
    output logic [5:0]        inhibit_o,
    output logic              sense_strobe_o,
    output logic              ack_o,
    output logic [5:0]        rdata_o,
    output logic              parity_err_o
);

    localparam int MAX_CYC = (READ_CYC > WRITE_CYC) ? READ_CYC : WRITE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_GAP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [5:0]        wdata_q;
    logic [5:0]        data_q;
    logic [ADDR_W-1:0] drv_addr_q;
    logic              busy_q;
    logic              drv_read_q;
    logic              drv_write_q;
    logic [5:0]        inhibit_q;
    logic              sense_strobe_q;
    logic              ack_q;
    logic [5:0]        rdata_q;
    logic [5:0]        write_word;

    // Word driven during WRITE: new data for a write, the sensed word to regenerate a read.
    assign write_word = we_q ? wdata_q : data_q;

`ifdef CORE_PARITY_CHECK_EN
    logic parity_err_q;
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    // Cycle FSM; every driver and status output is registered here so the core lines never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            data_q         <= '0;
            drv_addr_q     <= '0;
            busy_q         <= 1'b0;
            drv_read_q     <= 1'b0;
            drv_write_q    <= 1'b0;
            inhibit_q      <= '0;
            sense_strobe_q <= 1'b0;
            ack_q          <= 1'b0;
            rdata_q        <= '0;
`ifdef CORE_PARITY_CHECK_EN
            parity_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    if (req_i) begin
                        state_q        <= S_READ;
                        cnt_q          <= '0;
                        we_q           <= we_i;
                        wdata_q        <= wdata_i;
                        drv_addr_q     <= addr_i;
                        busy_q         <= 1'b1;
                        drv_read_q     <= 1'b1;
                        sense_strobe_q <= (READ_CYC == 1);
`ifdef CORE_PARITY_CHECK_EN
                        parity_err_q   <= 1'b0;
`endif
                    end
                end
                S_READ: begin
                    if (cnt_q == CNT_W'(READ_CYC - 1)) begin
                        // Destructive read completes: capture the sensed word as the current contents.
                        data_q         <= sense_i;
                        drv_read_q     <= 1'b0;
                        sense_strobe_q <= 1'b0;
                        state_q        <= S_GAP;
                    end else begin
                        cnt_q          <= cnt_q + 1'b1;
                        sense_strobe_q <= (cnt_q == CNT_W'(READ_CYC - 2));
                    end
                end
                S_GAP: begin
                    state_q     <= S_WRITE;
                    cnt_q       <= '0;
                    drv_write_q <= 1'b1;
                    inhibit_q   <= ~write_word;
                end
                S_WRITE: begin
                    if (cnt_q == CNT_W'(WRITE_CYC - 1)) begin
                        drv_write_q  <= 1'b0;
                        inhibit_q    <= '0;
                        ack_q        <= 1'b1;
                        rdata_q      <= data_q;
                        state_q      <= S_DONE;
`ifdef CORE_PARITY_CHECK_EN
                        parity_err_q <= ~^write_word;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Requests seen here are dropped; the next accept can only happen in IDLE.
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    drv_read_q  <= 1'b0;
                    drv_write_q <= 1'b0;
                    inhibit_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign drv_addr_o     = drv_addr_q;
    assign drv_read_o     = drv_read_q;
    assign drv_write_o    = drv_write_q;
    assign inhibit_o      = inhibit_q;
    assign sense_strobe_o = sense_strobe_q;
    assign ack_o          = ack_q;
    assign rdata_o        = rdata_q;

endmodule

// File: tb/tb_core_write_sequencer.sv
// tb/tb_core_write_sequencer.sv - directed self-checking bench for core_write_sequencer
module tb_core_write_sequencer;

`ifdef CORE_PARITY_CHECK_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b, we;
    logic [14:0] addr;
    logic [5:0]  wdata, sense;

    logic        a_busy, a_drv_read, a_drv_write, a_strobe, a_ack, a_perr;
    logic [14:0] a_drv_addr;
    logic [5:0]  a_inhibit, a_rdata;
    logic        b_busy, b_drv_read, b_drv_write, b_strobe, b_ack, b_perr;
    logic [14:0] b_drv_addr;
    logic [5:0]  b_inhibit, b_rdata;

    int total = 0;
    int bad   = 0;
    int acks;

    always #5 clk = ~clk;

    core_write_sequencer #(.ADDR_W(15), .READ_CYC(4), .WRITE_CYC(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .sense_i(sense), .busy_o(a_busy), .drv_addr_o(a_drv_addr),
        .drv_read_o(a_drv_read), .drv_write_o(a_drv_write), .inhibit_o(a_inhibit),
        .sense_strobe_o(a_strobe), .ack_o(a_ack), .rdata_o(a_rdata), .parity_err_o(a_perr)
    );

    core_write_sequencer #(.ADDR_W(15), .READ_CYC(1), .WRITE_CYC(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .sense_i(sense), .busy_o(b_busy), .drv_addr_o(b_drv_addr),
        .drv_read_o(b_drv_read), .drv_write_o(b_drv_write), .inhibit_o(b_inhibit),
        .sense_strobe_o(b_strobe), .ack_o(b_ack), .rdata_o(b_rdata), .parity_err_o(b_perr)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full default-timing cycle on dut_a, checked clock by clock from 1 to 11.
    task automatic run_op_a(input string tn, input logic w, input logic [14:0] a,
                            input logic [5:0] d, input logic [5:0] s,
                            input logic [5:0] inh, input logic pe);
        we = w; addr = a; wdata = d; sense = s; req_a = 1'b1;
        tick;
        req_a = 1'b0; we = ~w; addr = ~a; wdata = ~d;
        for (int c = 1; c <= 11; c++) begin
            chk({tn, ":drv_read"},  a_drv_read,  c <= 4);
            chk({tn, ":strobe"},    a_strobe,    c == 4);
            chk({tn, ":drv_write"}, a_drv_write, c >= 6 && c <= 9);
            chk({tn, ":inhibit"},   a_inhibit,   (c >= 6 && c <= 9) ? inh : 6'b0);
            chk({tn, ":ack"},       a_ack,       c == 10);
            chk({tn, ":busy"},      a_busy,      c <= 10);
            chk({tn, ":drv_addr"},  a_drv_addr,  a);
            chk({tn, ":exclusive"}, a_drv_read & a_drv_write, 0);
            if (c == 1)  chk({tn, ":perr_clear"}, a_perr, 0);
            if (c == 10) chk({tn, ":rdata"}, a_rdata, s);
            if (c == 10) chk({tn, ":perr"},  a_perr,  pe);
            if (c < 11) tick;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sense = '0;
        tick; tick;
        chk("rst:busy", a_busy, 0);
        chk("rst:drv_read", a_drv_read, 0);
        chk("rst:drv_write", a_drv_write, 0);
        chk("rst:inhibit", a_inhibit, 0);
        chk("rst:strobe", a_strobe, 0);
        chk("rst:ack", a_ack, 0);
        chk("rst:drv_addr", a_drv_addr, 0);
        chk("rst:rdata", a_rdata, 0);
        chk("rst:perr", a_perr, 0);
        rst_n = 1'b1;
        tick;

        // Reset mid-READ
        we = 1'b1; addr = 15'h0123; wdata = 6'b111111; sense = 6'b101010; req_a = 1'b1;
        tick;
        req_a = 1'b0;
        tick;
        chk("abort:pre_read", a_drv_read, 1);
        rst_n = 1'b0;
        #1;
        chk("abort:drv_read", a_drv_read, 0);
        chk("abort:busy", a_busy, 0);
        chk("abort:drv_addr", a_drv_addr, 0);
        tick; tick;
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            acks += int'(a_ack);
            chk("abort:idle_busy", a_busy, 0);
            chk("abort:idle_read", a_drv_read, 0);
        end
        chk("abort:no_ack", acks, 0);

        run_op_a("wr", 1'b1, 15'h1234, 6'b010101, 6'b000000, 6'b101010, 1'b0);
        run_op_a("par", 1'b1, 15'h0042, 6'b000011, 6'b010000, 6'b111100, PAR_ON);
        run_op_a("regen", 1'b0, 15'h2001, 6'b000000, 6'b100011, 6'b011100, 1'b0);

        // Busy rejection: req held high with a new address after accept
        we = 1'b1; addr = 15'h0AAA; wdata = 6'b000001; sense = 6'b000111; req_a = 1'b1;
        tick;
        addr = 15'h0555; wdata = 6'b110000; we = 1'b0;
        acks = 0;
        for (int c = 1; c <= 11; c++) begin
            acks += int'(a_ack);
            chk("busy:drv_addr_hold", a_drv_addr, 15'h0AAA);
            if (c == 10) chk("busy:rdata", a_rdata, 6'b000111);
            if (c == 11) chk("busy:idle", a_busy, 0);
            tick;
        end
        chk("busy:one_ack", acks, 1);
        chk("busy:second_addr", a_drv_addr, 15'h0555);
        chk("busy:second_busy", a_busy, 1);
        req_a = 1'b0;
        for (int c = 13; c <= 21; c++) begin
            tick;
            if (c == 21) chk("busy:second_ack", a_ack, 1);
        end
        tick;

        // Short timing on dut_b
        we = 1'b1; addr = 15'h7FFF; wdata = 6'b000111; sense = 6'b110000; req_b = 1'b1;
        tick;
        req_b = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk("short:drv_read",  b_drv_read,  c == 1);
            chk("short:strobe",    b_strobe,    c == 1);
            chk("short:drv_write", b_drv_write, c == 3 || c == 4);
            chk("short:inhibit",   b_inhibit,   (c == 3 || c == 4) ? 6'b111000 : 6'b0);
            chk("short:ack",       b_ack,       c == 5);
            chk("short:busy",      b_busy,      c <= 5);
            chk("short:exclusive", b_drv_read & b_drv_write, 0);
            chk("short:drv_addr",  b_drv_addr,  15'h7FFF);
            if (c == 5) chk("short:rdata", b_rdata, 6'b110000);
            if (c == 5) chk("short:perr",  b_perr,  0);
            tick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
